// File: rtl/display_pkg.sv
// display_pkg: definitions shared by the display scanner and the
// nibble-to-segment decoder.
//   NIBBLE_W           width of one displayed digit value
//   DEFAULT_NUM_DIGITS default number of scanned digit positions
//   DIG_SEL_ACTIVE     electrical level that enables a digit
//   nibble_t           one digit value
//   clog2_min1()       ceil(log2(value)), never less than 1, for counter widths
package display_pkg;

  localparam int   NIBBLE_W           = 4;
  localparam int   DEFAULT_NUM_DIGITS = 4;
  localparam logic DIG_SEL_ACTIVE     = 1'b1;

  typedef logic [NIBBLE_W-1:0] nibble_t;

  function automatic int clog2_min1(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/display_scan_refresh_tick.sv
// refresh_tick: free-running prescaler producing a digit-advance pulse.
// The counter runs 0..REFRESH_DIV-1; ADVANCE is high during the terminal
// count cycle, so it is a one-cycle pulse every REFRESH_DIV clocks
// (every cycle when REFRESH_DIV = 1).
// Ports:
//   CLK      system clock
//   RST_N    asynchronous active-low reset (counter -> 0)
//   ADVANCE  one-cycle pulse at the terminal count
module refresh_tick
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic CLK,
  input  logic RST_N,
  output logic ADVANCE
);

  localparam int               CNT_W = clog2_min1(REFRESH_DIV);
  localparam logic [CNT_W-1:0] TC    = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      cnt <= '0;
    end else if (cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign ADVANCE = (cnt == TC);

endmodule

// File: rtl/display_scan.sv
// display_scan: time-multiplexed digit scanner for a multi-digit
// seven-segment display. Holds a frame-stable value and selects one digit
// position at a time, presenting that digit's nibble to the segment decoder.
// Build option: define DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
// Ports:
//   CLK         system clock
//   RST_N       asynchronous active-low reset
//   DATA_IN     value to display, nibble 0 (bits 3:0) is the rightmost digit
//   LOAD_REQ    sample DATA_IN this cycle
//   LOAD_ACK    one-cycle pulse: the pending value became the displayed value
//   DIGIT_OUT   nibble of the currently selected digit
//   DIG_SEL     one-hot digit enable
//   BLANK       1 = current digit must be dark
//   FRAME_TICK  one-cycle pulse when the scan returns to digit 0
module display_scan
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV = 100000
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [NIBBLE_W*NUM_DIGITS-1:0] DATA_IN,
  input  logic                         LOAD_REQ,
  output logic                         LOAD_ACK,
  output logic [NIBBLE_W-1:0]          DIGIT_OUT,
  output logic [NUM_DIGITS-1:0]        DIG_SEL,
  output logic                         BLANK,
  output logic                         FRAME_TICK
);

  localparam int               DATA_W   = NIBBLE_W * NUM_DIGITS;
  localparam int               IDX_W    = clog2_min1(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic              advance;
  logic              wrap;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] disp;
  logic [DATA_W-1:0] pend;
  logic              pend_vld;
  logic              wrap_q;
  logic              ack_q;

  logic [NUM_DIGITS-1:0] sel_next;
  nibble_t               digit_next;
  logic                  blank_next;

  refresh_tick #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_refresh_tick (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ADVANCE(advance)
  );

  // Frame boundary: the advance that takes the index from the last digit
  // back to digit 0.
  assign wrap = advance && (idx == LAST_IDX);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      idx <= '0;
    end else if (advance) begin
      idx <= wrap ? '0 : idx + IDX_W'(1);
    end
  end

  // Load handshake: LOAD_REQ is a single-cycle request with no ready; every
  // asserted cycle captures DATA_IN (a later request overwrites an earlier
  // one still pending). The captured value is committed to the display only
  // at a frame boundary, and LOAD_ACK pulses exactly once per commit, in the
  // same cycle the new frame's digit 0 appears. A request in the boundary
  // cycle itself bypasses the pending register and commits at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      disp     <= '0;
      pend     <= '0;
      pend_vld <= 1'b0;
      wrap_q   <= 1'b0;
      ack_q    <= 1'b0;
    end else begin
      if (wrap && LOAD_REQ) begin
        disp     <= DATA_IN;
        pend_vld <= 1'b0;
      end else if (wrap && pend_vld) begin
        disp     <= pend;
        pend_vld <= 1'b0;
      end else if (LOAD_REQ) begin
        pend     <= DATA_IN;
        pend_vld <= 1'b1;
      end
      // Delayed one cycle so these line up with the registered outputs
      // that first show the new frame.
      wrap_q <= wrap;
      ack_q  <= wrap && (LOAD_REQ || pend_vld);
    end
  end

  // Select, nibble and blank flag all derive from the same index and
  // display register, so they stay aligned on the registered outputs.
  always_comb begin
    sel_next   = '0;
    digit_next = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        sel_next[i] = DIG_SEL_ACTIVE;
        digit_next  = disp[NIBBLE_W*i +: NIBBLE_W];
      end else begin
        sel_next[i] = ~DIG_SEL_ACTIVE;
      end
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // Walk from the most significant digit down, tracking whether every
  // nibble at or above the position is zero; digit 0 is never blanked.
  logic all_zero;
  always_comb begin
    all_zero   = 1'b1;
    blank_next = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero = all_zero && (disp[NIBBLE_W*i +: NIBBLE_W] == '0);
      if ((idx == IDX_W'(i)) && (i != 0)) blank_next = all_zero;
    end
  end
`else
  assign blank_next = 1'b0;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DIG_SEL    <= '0;
      DIGIT_OUT  <= '0;
      BLANK      <= 1'b1;
      LOAD_ACK   <= 1'b0;
      FRAME_TICK <= 1'b0;
    end else begin
      DIG_SEL    <= sel_next;
      DIGIT_OUT  <= digit_next;
      BLANK      <= blank_next;
      LOAD_ACK   <= ack_q;
      FRAME_TICK <= wrap_q;
    end
  end

endmodule
